branch_hazard_ctrl: RTL

Pipeline sequencing controller for the 16-bit 5-stage datapath. Consumes the ID-stage branch-resolution flush request and the ID/EX load-use information, and drives PC write/select, IF/ID write/flush and ID/EX bubble insertion. Sits between the branch equator and hazard compare logic in ID and the pipeline registers and PC mux. Multi-cycle penalties are sequenced by a small FSM with a down-counter.

---
 rtl/branch_ctrl_pkg.sv | 28 ++
 rtl/branch_hazard_ctrl_penalty_counter.sv | 31 +++
 rtl/branch_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch/hazard sequencing controller.
// Optional statistics counters are enabled with `define BRANCH_CTRL_STATS_EN.
package branch_ctrl_pkg;

  // Longest penalty either multi-cycle sequence may be configured for.
  localparam int MAX_PENALTY = 7;

  // Penalty down-counter width; wide enough to hold MAX_PENALTY.
  localparam int CNT_W = $clog2(MAX_PENALTY + 1);

  // Statistics counter width and saturation value.
  localparam int          STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Counter preload for a penalty of 'cycles'. The first penalty cycle is
  // spent in RUN, so the multi-cycle state only covers the remainder.
  function automatic logic [CNT_W-1:0] penalty_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_penalty_counter.sv
// Penalty down-counter shared by the load-use stall and redirect flush
// sequences. 'done' flags the final cycle of a sequence (count of one).
module penalty_counter
  import branch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // Load takes precedence over decrement; never wraps below zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline sequencing controller: turns the ID-stage branch redirect and
// the ID/EX load-use hazard into PC, IF/ID and ID/EX control, with a small
// FSM plus shared down-counter for multi-cycle penalties.
// Priority: mem_stall > load-use hazard > branch_flush.
// Optional statistics: `define BRANCH_CTRL_STATS_EN to build the saturating
// flush/stall counters; otherwise those ports are tied to zero.
module branch_hazard_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int LU_CYCLES    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_stall,
  input  logic              branch_flush,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  output logic              pc_write,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              busy,
  output logic [STAT_W-1:0] flush_count,
  output logic [STAT_W-1:0] stall_count
);

  // Out-of-range penalties would leave the counter unable to reach 'done'.
  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > MAX_PENALTY)) begin : g_bad_flush
    $error("branch_hazard_ctrl: FLUSH_CYCLES must be 1..7");
  end
  if ((LU_CYCLES < 1) || (LU_CYCLES > MAX_PENALTY)) begin : g_bad_lu
    $error("branch_hazard_ctrl: LU_CYCLES must be 1..7");
  end

  localparam logic [CNT_W-1:0] LU_LOAD    = penalty_load(LU_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = penalty_load(FLUSH_CYCLES);
  localparam bit               LU_MULTI    = (LU_CYCLES > 1);
  localparam bit               FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_target_q;
  logic              hazard;
  logic              redirect;
  logic              bubble;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_done;

  // Register 0 is hard-wired zero, so a load targeting it never hazards.
  assign hazard = idex_mem_read && (idex_rd != '0) &&
                  ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                   (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

  // Next-state and pipeline control decode from current state and requests.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    redirect     = 1'b0;
    bubble       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (!reset_n) begin
      // Hold both pipeline registers at NOP and the PC frozen in reset.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_stall) begin
      // Whole pipeline frozen; state and counter hold.
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            // Branch operands may be stale; it re-evaluates after the stall.
            bubble = 1'b1;
            if (LU_MULTI) begin
              state_d      = LU_STALL;
              cnt_load     = 1'b1;
              cnt_load_val = LU_LOAD;
            end
          end else if (branch_flush) begin
            redirect   = 1'b1;
            pc_write   = 1'b1;
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            if (FLUSH_MULTI) begin
              state_d      = FLUSH;
              cnt_load     = 1'b1;
              cnt_load_val = FLUSH_LOAD;
            end
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        LU_STALL: begin
          bubble  = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_done) state_d = RUN;
        end
        FLUSH: begin
          // Fetch continues sequentially from the target; the fetched
          // wrong-path instruction is squashed and any branch ignored.
          pc_write   = 1'b1;
          ifid_flush = 1'b1;
          cnt_dec    = 1'b1;
          if (cnt_done) state_d = RUN;
        end
        default: state_d = RUN;
      endcase

      if (bubble) begin
        idex_flush = 1'b1;
      end
    end
  end

  // State and captured redirect target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      pc_target_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) pc_target_q <= branch_target;
    end
  end

  penalty_counter u_penalty_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // The accepted target passes straight through in its redirect cycle.
  assign pc_target = redirect ? branch_target : pc_target_q;
  assign busy      = (state_q != RUN);

`ifdef BRANCH_CTRL_STATS_EN
  logic [STAT_W-1:0] flush_cnt_q;
  logic [STAT_W-1:0] stall_cnt_q;

  // Saturating counts of accepted redirects and inserted bubble cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redirect && (flush_cnt_q != STAT_MAX)) flush_cnt_q <= flush_cnt_q + 16'd1;
      if (bubble && (stall_cnt_q != STAT_MAX))   stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign flush_count = flush_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign flush_count = '0;
  assign stall_count = '0;
`endif

endmodule
